avalon_pio_debounce: RTL and testbench
======================================

# avalon_pio_debounce

Parametrised Avalon-MM PIO peripheral that replaces the fixed 2-bit button input and 10-bit LED output PIOs in the Qsys system with one configurable block. It synchronises and debounces N inputs and captures selectable edges into sticky bits. It raises a maskable interrupt and drives M outputs through direct, set and clear registers. It sits on the system interconnect as a single slave with fixed read latency 1.

## Interface
Parameters:
- IN_WIDTH, default 2: number of input channels, 1..32.
- OUT_WIDTH, default 10: number of output channels, 1..32.
- DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required; ≥1. At 50 MHz the default is 1 ms.
- IN_IDLE, default all ones: reset value of the synchroniser and debounced state. Board buttons are active-low.
- OUT_RESET, default 0: reset value of the output register.

Ports:
- clk_clk  in  1  sole clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid the cycle after avs_read.
- irq  out  1  level interrupt, registered.
- button_export  in  IN_WIDTH  asynchronous raw inputs.
- led_export  out  OUT_WIDTH  output register contents.

## Operation
- Register map (word address: function):
  - 0 DATA: read-only, returns the debounced inputs.
  - 1 OUT: read/write output register.
  - 2 OUT_SET: write-1 sets OUT bits; reads return OUT.
  - 3 OUT_CLR: write-1 clears OUT bits; reads return OUT.
  - 4 IRQ_MASK: read/write.
  - 5 EDGE_CAP: sticky capture bits; write-1 clears them.
  - 6 EDGE_SEL: read/write; per channel, 1 = rising edge, 0 = falling edge.
  - 7 CONFIG: read-only; bits [5:0] = IN_WIDTH, bits [13:8] = OUT_WIDTH, other bits 0.
- Unused upper bits read 0; writes to unused bits and to read-only registers are ignored.
- Input path, per channel:
  - Two-flop synchroniser feeds a debouncer holding `stable` and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - While sync ≠ stable the counter increments. When it reaches DEBOUNCE_CYCLES, stable takes the sync value and the counter returns to 0.
  - Whenever sync = stable the counter is 0. Any glitch shorter than DEBOUNCE_CYCLES never reaches `stable`.
- Edge capture: when `stable` changes in the direction selected by EDGE_SEL, the matching EDGE_CAP bit is set.
- irq is registered from the OR-reduction of EDGE_CAP & IRQ_MASK.
- Simultaneous events:
  - Edge-set and write-1-clear on the same EDGE_CAP bit: set wins.
  - Read and write in the same cycle: both act; readdata returns the pre-write value.
- Reset values: led_export = OUT_RESET; avs_readdata = 0; irq = 0; IRQ_MASK, EDGE_CAP, EDGE_SEL = 0; synchronisers and stable = IN_IDLE; counters = 0.
- Reset asserted mid-debounce discards the count. No edge is captured on reset release unless the pins differ from IN_IDLE for DEBOUNCE_CYCLES cycles.

## Timing
- Write latency: register and led_export change at the edge that samples avs_write, visible the following cycle.
- Read latency is fixed at 1 cycle; there is no waitrequest.
- Pin-to-stable latency: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles.
- EDGE_CAP sets one cycle after `stable` changes; irq asserts one cycle after that.
- irq deasserts one cycle after a clear or mask write removes the last pending enabled bit.

## Structure
- Package avalon_pio_pkg holds:
  - register address constants (ADDR_DATA … ADDR_CONFIG);
  - CONFIG field positions;
  - the maximum width limit of 32.
- Sub-module pio_debounce_channel contains the synchroniser, counter and stable register, with parameters DEBOUNCE_CYCLES and IDLE. It is instantiated IN_WIDTH times by generate.
- The top level holds the register file, edge detection, irq and the read mux.

## Test plan
Benches run with DEBOUNCE_CYCLES=4, IN_WIDTH=2, OUT_WIDTH=10.
- Reset: after reset, led_export=0x000, irq=0, DATA reads 0x3, CONFIG reads 0x00000A02.
- Output registers: write OUT=0x155, then OUT_SET=0x00A, then OUT_CLR=0x100 -> led_export 0x155, 0x15F, 0x05F on successive cycles; OUT reads 0x05F.
- Debounce filtering:
  - Drive button_export[0] low for 3 cycles, then high -> DATA stays 0x3 and EDGE_CAP stays 0.
  - Hold it low for 10 cycles -> DATA reads 0x2 exactly 6 cycles after the pin change.
- Edge interrupt:
  - EDGE_SEL=0, IRQ_MASK=0x1, press button 0 -> EDGE_CAP=0x1 and irq=1.
  - Write EDGE_CAP=0x1 -> irq=0 next cycle.
  - Release the button -> no capture (rising edge not selected).
- Simultaneous set and clear: time a write-1-clear of EDGE_CAP[1] in the same cycle as a new falling edge on channel 1 -> EDGE_CAP[1] remains 1.
- Reset mid-debounce: assert reset_reset_n low 2 cycles into a press, release, keep the pin high -> DATA=0x3 and no capture.

Source files
------------

// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM debounced PIO peripheral.
// Holds the register word addresses, the CONFIG field layout, the channel
// width limit and a helper that packs the CONFIG word.
package avalon_pio_pkg;

    localparam int MAX_WIDTH = 32;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_OUT      = 3'd1;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd2;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd6;
    localparam logic [2:0] ADDR_CONFIG   = 3'd7;

    // CONFIG word: [5:0] input width, [13:8] output width, rest zero.
    localparam int CFG_IN_LSB  = 0;
    localparam int CFG_OUT_LSB = 8;
    localparam int CFG_FIELD_W = 6;

    function automatic logic [31:0] cfg_word(input int in_w, input int out_w);
        logic [31:0] w;
        w = 32'd0;
        w[CFG_IN_LSB  +: CFG_FIELD_W] = in_w[CFG_FIELD_W-1:0];
        w[CFG_OUT_LSB +: CFG_FIELD_W] = out_w[CFG_FIELD_W-1:0];
        return w;
    endfunction

endpackage

// File: rtl/pio_debounce_channel.sv
// One input channel: two-flop synchroniser followed by a debouncer.
// The debounced value only follows the synchronised pin after it has
// disagreed with the current debounced value for DEBOUNCE_CYCLES
// consecutive cycles; any shorter excursion restarts the count.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   pin    - raw asynchronous input
//   stable - debounced output (registered)
module pio_debounce_channel #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE            = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic stable
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    // The mismatch cycle that reaches CNT_LAST is the DEBOUNCE_CYCLES-th one.
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;

    // Synchroniser, mismatch counter and debounced state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r  <= IDLE;
            sync2_r  <= IDLE;
            stable_r <= IDLE;
            cnt_r    <= '0;
        end else begin
            sync1_r <= pin;
            sync2_r <= sync1_r;
            if (sync2_r == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= sync2_r;
                cnt_r    <= '0;
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stable = stable_r;

endmodule

// File: rtl/avalon_pio_debounce.sv
// Avalon-MM PIO slave with debounced inputs, edge capture and interrupt.
// Ports:
//   clk_clk, reset_reset_n         - clock, asynchronous active-low reset
//   avs_address/read/write/...     - Avalon-MM slave, fixed read latency 1
//   irq                            - registered level interrupt
//   button_export                  - raw asynchronous inputs
//   led_export                     - output register contents
module avalon_pio_debounce
    import avalon_pio_pkg::*;
#(
    parameter int                  IN_WIDTH        = 2,
    parameter int                  OUT_WIDTH       = 10,
    parameter int                  DEBOUNCE_CYCLES = 50000,
    parameter logic [IN_WIDTH-1:0] IN_IDLE         = '1,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET      = '0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  button_export,
    output logic [OUT_WIDTH-1:0] led_export
);

    localparam logic [31:0] CONFIG_WORD = cfg_word(IN_WIDTH, OUT_WIDTH);

    logic [IN_WIDTH-1:0]  stable_s;
    logic [IN_WIDTH-1:0]  stable_d_r;
    logic [IN_WIDTH-1:0]  hit_s;
    logic [IN_WIDTH-1:0]  cap_clr_s;
    logic [IN_WIDTH-1:0]  cap_r;
    logic [IN_WIDTH-1:0]  mask_r;
    logic [IN_WIDTH-1:0]  sel_r;
    logic [OUT_WIDTH-1:0] out_r;
    logic [31:0]          rd_s;
    logic [31:0]          rd_r;
    logic                 irq_r;
    logic                 unused_wdata_s;

    // Upper write-data bits beyond the channel widths are ignored.
    assign unused_wdata_s = ^avs_writedata;

    for (genvar g = 0; g < IN_WIDTH; g++) begin : g_ch
        pio_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE            (IN_IDLE[g])
        ) u_ch (
            .clk    (clk_clk),
            .rst_n  (reset_reset_n),
            .pin    (button_export[g]),
            .stable (stable_s[g])
        );
    end

    // Selected-direction edge on the debounced inputs; stable_d_r resets to
    // the idle level so reset release alone never looks like an edge.
    always_comb begin
        hit_s = (sel_r & stable_s & ~stable_d_r) | (~sel_r & ~stable_s & stable_d_r);
    end

    // Write-1-clear request for EDGE_CAP.
    always_comb begin
        if (avs_write && (avs_address == ADDR_EDGE_CAP)) begin
            cap_clr_s = avs_writedata[IN_WIDTH-1:0];
        end else begin
            cap_clr_s = '0;
        end
    end

    // Register file, edge capture (set beats clear) and interrupt.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stable_d_r <= IN_IDLE;
            cap_r      <= '0;
            mask_r     <= '0;
            sel_r      <= '0;
            out_r      <= OUT_RESET;
            irq_r      <= 1'b0;
        end else begin
            stable_d_r <= stable_s;
            cap_r      <= (cap_r & ~cap_clr_s) | hit_s;
            irq_r      <= |(cap_r & mask_r);
            if (avs_write) begin
                case (avs_address)
                    ADDR_OUT:      out_r  <= avs_writedata[OUT_WIDTH-1:0];
                    ADDR_OUT_SET:  out_r  <= out_r | avs_writedata[OUT_WIDTH-1:0];
                    ADDR_OUT_CLR:  out_r  <= out_r & ~avs_writedata[OUT_WIDTH-1:0];
                    ADDR_IRQ_MASK: mask_r <= avs_writedata[IN_WIDTH-1:0];
                    ADDR_EDGE_SEL: sel_r  <= avs_writedata[IN_WIDTH-1:0];
                    default:       out_r  <= out_r;
                endcase
            end else begin
                out_r <= out_r;
            end
        end
    end

    // Read mux over the current (pre-write) register values.
    always_comb begin
        rd_s = 32'd0;
        case (avs_address)
            ADDR_DATA:     rd_s[IN_WIDTH-1:0]  = stable_s;
            ADDR_OUT,
            ADDR_OUT_SET,
            ADDR_OUT_CLR:  rd_s[OUT_WIDTH-1:0] = out_r;
            ADDR_IRQ_MASK: rd_s[IN_WIDTH-1:0]  = mask_r;
            ADDR_EDGE_CAP: rd_s[IN_WIDTH-1:0]  = cap_r;
            ADDR_EDGE_SEL: rd_s[IN_WIDTH-1:0]  = sel_r;
            ADDR_CONFIG:   rd_s                = CONFIG_WORD;
            default:       rd_s                = 32'd0;
        endcase
    end

    // Read data register: one-cycle read latency, zero when idle.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rd_r <= 32'd0;
        end else if (avs_read) begin
            rd_r <= rd_s;
        end else begin
            rd_r <= 32'd0;
        end
    end

    assign avs_readdata = rd_r;
    assign irq          = irq_r;
    assign led_export   = out_r;

endmodule

// File: tb/tb_avalon_pio_debounce.sv
// Directed-vector bench for avalon_pio_debounce (DEBOUNCE_CYCLES=4,
// IN_WIDTH=2, OUT_WIDTH=10). Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, away from the active edge.
module tb_avalon_pio_debounce;

    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_OUT  = 3'd1;
    localparam logic [2:0] A_SET  = 3'd2;
    localparam logic [2:0] A_CLR  = 3'd3;
    localparam logic [2:0] A_MASK = 3'd4;
    localparam logic [2:0] A_CAP  = 3'd5;
    localparam logic [2:0] A_SEL  = 3'd6;
    localparam logic [2:0] A_CFG  = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;
    logic [1:0]  button = 2'b11;
    logic [9:0]  led;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] d;

    always #5 clk = ~clk;

    avalon_pio_debounce #(
        .IN_WIDTH        (2),
        .OUT_WIDTH       (10),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .avs_address    (address),
        .avs_read       (read),
        .avs_write      (write),
        .avs_writedata  (wdata),
        .avs_readdata   (rdata),
        .irq            (irq),
        .button_export  (button),
        .led_export     (led)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        address = a;
        wdata   = v;
        write   = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        address = a;
        read    = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
        v    = rdata;
    endtask

    initial begin
        // Reset
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check_vec("rst_led", {22'd0, led}, 32'h000);
        check_vec("rst_irq", {31'd0, irq}, 32'd0);
        rd(A_DATA, d); check_vec("rst_data", d, 32'h3);
        rd(A_CFG, d);  check_vec("config", d, 32'h0000_0A02);

        // Output registers on successive cycles
        wr(A_OUT, 32'h155); check_vec("led_out", {22'd0, led}, 32'h155);
        wr(A_SET, 32'h00A); check_vec("led_set", {22'd0, led}, 32'h15F);
        wr(A_CLR, 32'h100); check_vec("led_clr", {22'd0, led}, 32'h05F);
        rd(A_OUT, d); check_vec("rd_out", d, 32'h05F);
        rd(A_SET, d); check_vec("rd_out_set", d, 32'h05F);

        // Read and write together: read sees the old value, upper bits dropped
        address = A_OUT; wdata = 32'hFFFF_FFFF; write = 1'b1; read = 1'b1;
        tick(1);
        write = 1'b0; read = 1'b0;
        check_vec("rw_old", rdata, 32'h05F);
        check_vec("rw_led", {22'd0, led}, 32'h3FF);
        rd(A_OUT, d); check_vec("rd_out_wide", d, 32'h3FF);

        // 3-cycle glitch on channel 0 is filtered
        button[0] = 1'b0; tick(3); button[0] = 1'b1;
        tick(10);
        rd(A_DATA, d); check_vec("glitch_data", d, 32'h3);
        rd(A_CAP, d);  check_vec("glitch_cap", d, 32'h0);

        // Long press: debounced state flips at edge 6 after the pin change,
        // so the continuous read shows it on edge 7.
        button[0] = 1'b0; address = A_DATA; read = 1'b1;
        tick(6); check_vec("db_edge6", rdata, 32'h3);
        tick(1); check_vec("db_edge7", rdata, 32'h2);
        read = 1'b0;
        tick(3);
        button[0] = 1'b1;
        tick(10);
        rd(A_CAP, d); check_vec("cap_masked", d, 32'h1);
        check_vec("irq_masked", {31'd0, irq}, 32'd0);
        wr(A_CAP, 32'h3);
        rd(A_CAP, d); check_vec("cap_cleared", d, 32'h0);

        // Edge interrupt on channel 0, falling edge
        wr(A_SEL, 32'h0);
        wr(A_MASK, 32'h1);
        rd(A_MASK, d); check_vec("rd_mask", d, 32'h1);
        button[0] = 1'b0;
        tick(10);
        rd(A_CAP, d); check_vec("irq_cap", d, 32'h1);
        check_vec("irq_set", {31'd0, irq}, 32'd1);
        wr(A_CAP, 32'h1);
        check_vec("irq_hold", {31'd0, irq}, 32'd1);
        tick(1);
        check_vec("irq_clear", {31'd0, irq}, 32'd0);
        button[0] = 1'b1;
        tick(10);
        rd(A_CAP, d); check_vec("release_cap", d, 32'h0);
        check_vec("release_irq", {31'd0, irq}, 32'd0);

        // Channel 1: prime EDGE_CAP[1], then clear it in the cycle it re-sets
        button[1] = 1'b0; tick(10); button[1] = 1'b1; tick(10);
        rd(A_CAP, d); check_vec("ch1_prime", d, 32'h2);
        button[1] = 1'b0;
        tick(6);
        wr(A_CAP, 32'h2);
        rd(A_CAP, d); check_vec("set_wins", d, 32'h2);
        check_vec("set_wins_irq", {31'd0, irq}, 32'd0);
        button[1] = 1'b1;
        tick(10);
        wr(A_CAP, 32'h3);
        rd(A_CAP, d); check_vec("ch1_cleared", d, 32'h0);

        // Reset two cycles into a press
        button[0] = 1'b0;
        tick(2);
        rst_n = 1'b0;
        button[0] = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        rd(A_DATA, d); check_vec("rst_mid_data", d, 32'h3);
        rd(A_CAP, d);  check_vec("rst_mid_cap", d, 32'h0);
        rd(A_MASK, d); check_vec("rst_mid_mask", d, 32'h0);
        check_vec("rst_mid_led", {22'd0, led}, 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
